fetch_buffer: RTL
=================

Name: fetch_buffer

Overview:
- Instruction buffer directly downstream of the fetch queue / ICache read stage.
- Captures each fetched {pc, bid, instruction} and presents it in order to decode through a valid/ready handshake.
- Drives the registered, active-high not-ready (readyn) that throttles the fetch queue. The threshold absorbs the fetch queue's 1-cycle readyn register plus the ICache access latency.
- Flushed on branch commit override or ICache snoop hit.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.
- ADDR_WIDTH, 3, log2(DEPTH).
- READYN_THRESHOLD, 3, readyn asserts when free entries after the current cycle are <= this value; must be < DEPTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- resetn  input  1  synchronous reset, active-low.
- in_valid  input  1  fetched instruction valid, already qualified by cache hit / refill / uncached done.
- in_pc  input  32  virtual PC of the fetched instruction.
- in_bid  input  4  branch block id from the fetch queue.
- in_instr  input  32  instruction word.
- flush  input  1  bco_valid | snoop_hit; discards all contents.
- readyn  output  1  registered; high means the fetch queue must stop shifting.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode accepts the head this cycle.
- out_pc  output  32  head PC.
- out_bid  output  4  head bid.
- out_instr  output  32  head instruction.
- count  output  ADDR_WIDTH+1  occupied entries, 0..DEPTH.
- overflow  output  1  sticky error: a write was dropped while full.

Behaviour:
- Storage: circular register array; wptr and rptr are ADDR_WIDTH bits and wrap DEPTH-1 -> 0; count is a separate register.
- Reset (resetn=0 at posedge): wptr=rptr=0, count=0, readyn=0, overflow=0. Consequently out_valid=0. Array contents are don't-care.
- rd = out_valid & out_ready. out_valid = (count != 0), a combinational decode of the registered count. out_* read the array at rptr combinationally.
- wr = in_valid & ~flush & (count != DEPTH | rd). Write on full is accepted only when a read happens in the same cycle.
- Drop = in_valid & ~flush & (count == DEPTH) & ~rd. Drop sets overflow to 1; overflow is cleared only by reset, not by flush.
- count_next = count + wr - rd. Simultaneous wr and rd leaves count unchanged and advances both pointers.
- readyn <= (DEPTH - count_next) <= READYN_THRESHOLD. Effective latency to the fetch queue: readyn at cycle N+1 reflects state after cycle N.
- Flush has priority over everything:
  - wptr=rptr=0, count=0, readyn<=0.
  - The same-cycle in_valid is discarded.
  - A same-cycle rd still completes at the decode side: the head is considered consumed, so the decoder must drop it itself on flush.
- Empty: out_valid=0; out_* hold stale data and are don't-care.
- Full: count=DEPTH, readyn=1 by construction whenever READYN_THRESHOLD >= 0.
- No internal FSM beyond the pointers and count. Occupancy states are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH), with transitions implied by count_next.
- Properties the implementation must satisfy:
  - In-order delivery.
  - No duplication.
  - With a correctly sized threshold, no drop under a fetch queue honouring readyn.

Optional Feature:
- Macro: FETCH_BUFFER_BYPASS_EN.
- Defined: when count==0 and in_valid & ~flush:
  - out_valid=1 combinationally in the same cycle.
  - out_* = in_*.
  - If out_ready=1, the entry is consumed without being written: wptr, rptr and count are unchanged.
  - If out_ready=0, it is written normally.
  - This gives 0-cycle latency.
- Not defined: minimum latency is 1 cycle (write at cycle N, out_valid at N+1); out_valid depends only on count.

Test Plan:
- Reset then 8 back-to-back writes (pc 0x80000000+4i, bid 0) with out_ready=0 -> count reaches 8. readyn first rises the cycle after the 5th write (free=3). overflow=0. A 9th in_valid while full -> dropped, overflow=1.
- Fill 4 entries, then out_ready=1 with no writes -> out_pc sequence 0x80000000, 04, 08, 0C on consecutive cycles. count reaches 0, out_valid=0 in the cycle after the last read, readyn=0.
- Full buffer, in_valid=1 and out_ready=1 in the same cycle -> write accepted, count stays 8, no overflow. Pointers wrap through index 7 -> 0 with correct order after 12 mixed operations.
- 5 entries present; flush=1 together with in_valid=1 (pc 0x9FC00000) -> next cycle count=0, out_valid=0, readyn=0. The following write of pc 0x9FC00004 appears as head.
- Assert resetn=0 while count=6 and readyn=1 -> next cycle count=0, readyn=0, overflow=0, out_valid=0.
- With FETCH_BUFFER_BYPASS_EN: empty buffer, in_valid=1, out_ready=1, pc 0x80000100 -> out_valid=1 and out_pc=0x80000100 in the same cycle; count stays 0. Without the macro: out_valid=1 one cycle later, count=1 in between.

Source files
------------

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//
// Instruction buffer between the fetch queue / ICache read stage and decode.
// Each fetched {pc, bid, instr} is captured in a circular register array and
// presented in order to decode through a valid/ready handshake. A registered
// readyn throttles the fetch queue early enough to absorb the queue's own
// readyn register plus the ICache access latency. A flush (branch commit
// override or snoop hit) discards all contents.
//
// Parameters:
//   DEPTH             number of entries (power of two, >= 4)
//   ADDR_WIDTH        log2(DEPTH)
//   READYN_THRESHOLD  readyn asserts when free entries after this cycle
//                     are <= this value (must be < DEPTH)
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   resetn     in   synchronous reset, active-low
//   in_valid   in   fetched instruction valid
//   in_pc      in   [31:0] PC of the fetched instruction
//   in_bid     in   [3:0]  branch block id
//   in_instr   in   [31:0] instruction word
//   flush      in   discard all contents (and the same-cycle input)
//   readyn     out  registered stop request to the fetch queue
//   out_valid  out  head entry valid
//   out_ready  in   decode accepts the head this cycle
//   out_pc     out  [31:0] head PC
//   out_bid    out  [3:0]  head bid
//   out_instr  out  [31:0] head instruction
//   count      out  [ADDR_WIDTH:0] occupied entries, 0..DEPTH
//   overflow   out  sticky: a write was dropped while full (reset clears)
//
// Build option:
//   FETCH_BUFFER_BYPASS_EN  when defined, an input arriving at an empty
//                           buffer is presented to decode in the same cycle
//                           and is not stored if decode takes it at once.
// ---------------------------------------------------------------------------
module fetch_buffer #(
    parameter int DEPTH            = 8,
    parameter int ADDR_WIDTH       = 3,
    parameter int READYN_THRESHOLD = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic [31:0]           in_pc,
    input  logic [3:0]            in_bid,
    input  logic [31:0]           in_instr,
    input  logic                  flush,
    output logic                  readyn,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [3:0]            out_bid,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] LP_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_THRESH = (ADDR_WIDTH+1)'(READYN_THRESHOLD);

    logic [31:0]           r_pc    [DEPTH];
    logic [3:0]            r_bid   [DEPTH];
    logic [31:0]           r_instr [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_readyn;
    logic                  r_overflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_bypass;
    logic                  w_bypass_take;
    logic                  w_rd;
    logic                  w_rd_mem;
    logic                  w_wr;
    logic                  w_drop;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic [ADDR_WIDTH:0]   w_free_next;
    logic                  w_readyn_next;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LP_DEPTH);

`ifdef FETCH_BUFFER_BYPASS_EN
    assign w_bypass = w_empty & in_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign out_valid = ~w_empty | w_bypass;
    assign out_pc    = w_bypass ? in_pc    : r_pc[r_rptr];
    assign out_bid   = w_bypass ? in_bid   : r_bid[r_rptr];
    assign out_instr = w_bypass ? in_instr : r_instr[r_rptr];

    assign w_rd = out_valid & out_ready;

    // A bypassed input taken by decode in the same cycle never touches the
    // array: no write, no read, pointers and count stay put.
    assign w_bypass_take = w_bypass & out_ready;
    assign w_rd_mem      = w_rd & ~w_bypass_take;

    // Writing into a full buffer is fine when the head leaves this cycle.
    assign w_wr   = in_valid & ~flush & (~w_full | w_rd) & ~w_bypass_take;
    assign w_drop = in_valid & ~flush & w_full & ~w_rd;

    assign w_count_next  = r_count + (ADDR_WIDTH+1)'(w_wr) - (ADDR_WIDTH+1)'(w_rd_mem);
    assign w_free_next   = LP_DEPTH - w_count_next;
    assign w_readyn_next = (w_free_next <= LP_THRESH);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_readyn   <= 1'b0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            // overflow is deliberately sticky across flushes
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_readyn <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + ADDR_WIDTH'(1);
            end
            if (w_rd_mem) begin
                r_rptr <= r_rptr + ADDR_WIDTH'(1);
            end
            r_count  <= w_count_next;
            r_readyn <= w_readyn_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (resetn && w_wr) begin
            r_pc[r_wptr]    <= in_pc;
            r_bid[r_wptr]   <= in_bid;
            r_instr[r_wptr] <= in_instr;
        end
    end

    assign readyn   = r_readyn;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
